// File: rtl/pwm_meas_if.sv
// pwm_meas_if: measurement result bus between the PWM meter and its consumer.
interface pwm_meas_if #(parameter int W = 32);
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         meas_valid;
  logic         meas_ack;
  logic         overrun;
  logic         stuck;
  logic         stuck_level;
  modport master (output high_cnt, period_cnt, meas_valid, overrun, stuck, stuck_level, input meas_ack);
  modport slave  (input high_cnt, period_cnt, meas_valid, overrun, stuck, stuck_level, output meas_ack);
endinterface

// File: rtl/pwm_meas.sv
// pwm_meas: measures period and high time of an asynchronous PWM input in clk cycles.
module pwm_meas #(
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pwm_in,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] timeout,
  pwm_meas_if.master               bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0]   sync;
  logic [COUNTER_WIDTH-1:0] pcnt, hcnt;
  logic s, s_d, rise, en_d, en_rise, capture, expire, load;
  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign en_rise = enable & ~en_d;
  always_comb begin
    capture  = 1'b0;
    expire   = 1'b0;
    load     = 1'b0;
    state_nx = state;
    capture  = enable && state == RUN && rise;
    expire   = enable && state == RUN && !rise && |timeout && pcnt >= timeout;
    load     = enable && rise && state != IDLE;
    state_nx = !enable                 ? IDLE :
               state == IDLE           ? ARM  :
               (state == ARM && rise)  ? RUN  :
               expire                  ? ARM  : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // A rise reloads the counters to 1 because the rise cycle itself belongs to the new period.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync            <= '0;
      s_d             <= 1'b0;
      en_d            <= 1'b0;
      pcnt            <= '0;
      hcnt            <= '0;
      bus.high_cnt    <= '0;
      bus.period_cnt  <= '0;
      bus.meas_valid  <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.stuck       <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      sync            <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d             <= s;
      en_d            <= enable;
      pcnt            <= load ? COUNTER_WIDTH'(1) : (enable && state == RUN && pcnt != '1) ? pcnt + 1'b1 : pcnt;
      hcnt            <= load ? COUNTER_WIDTH'(1) : (enable && state == RUN && s && hcnt != '1) ? hcnt + 1'b1 : hcnt;
      bus.high_cnt    <= capture ? hcnt : bus.high_cnt;
      bus.period_cnt  <= capture ? pcnt : bus.period_cnt;
      bus.meas_valid  <= capture ? 1'b1 : bus.meas_ack ? 1'b0 : bus.meas_valid;
      bus.overrun     <= en_rise ? 1'b0 : (capture && bus.meas_valid && !bus.meas_ack) ? 1'b1 : bus.overrun;
      bus.stuck       <= en_rise ? 1'b0 : expire ? 1'b1 : bus.stuck;
      bus.stuck_level <= expire ? s : bus.stuck_level;
    end
endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: directed checks of pwm_meas in an 8-bit counter build.
module tb_pwm_meas;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] timeout = '0;
  int total = 0;
  int bad = 0;
  pwm_meas_if #(.W(8)) bus ();
  pwm_meas #(.SYNC_STAGES(2), .COUNTER_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable), .timeout(timeout), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // One PWM period: h cycles high then l low; optional ack lands on the capture edge.
  task automatic pwm(input int h, input int l, input bit ack);
    for (int i = 0; i < h + l; i++) begin
      pwm_in = (i < h);
      bus.meas_ack = ack && (i == 2);
      @(negedge clk);
    end
    bus.meas_ack = 1'b0;
  endtask
  task automatic ack_pulse();
    bus.meas_ack = 1'b1;
    @(negedge clk);
    bus.meas_ack = 1'b0;
  endtask
  task automatic chk_res(input string tag, input int p, input int h, input bit v);
    chk({tag, "_period"}, bus.period_cnt, p);
    chk({tag, "_high"}, bus.high_cnt, h);
    chk({tag, "_valid"}, bus.meas_valid, v);
  endtask
  initial begin
    bus.meas_ack = 1'b0;
    tick(2);
    chk_res("reset", 0, 0, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_stuck", bus.stuck, 0);
    chk("reset_stuck_level", bus.stuck_level, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1);
    pwm(3, 5, 0);
    chk("arm_no_capture", bus.meas_valid, 0);
    pwm(2, 7, 0);
    chk_res("first", 8, 3, 1);
    chk("first_overrun", bus.overrun, 0);
    pwm(5, 3, 1);
    chk_res("ack_coincident", 9, 2, 1);
    chk("ack_coincident_overrun", bus.overrun, 0);
    pwm(4, 4, 0);
    chk_res("overwrite", 8, 5, 1);
    chk("overwrite_overrun", bus.overrun, 1);
    ack_pulse();
    chk("ack_clears_valid", bus.meas_valid, 0);
    ack_pulse();
    chk_res("ack_idle", 8, 5, 0);
    chk("ack_idle_overrun", bus.overrun, 1);
    pwm(1, 7, 0);
    chk_res("long_period", 10, 4, 1);
    timeout = 8'd20;
    tick(14);
    chk("stuck_before", bus.stuck, 0);
    tick(1);
    chk("stuck_set", bus.stuck, 1);
    chk("stuck_level", bus.stuck_level, 0);
    chk_res("stuck_results", 10, 4, 1);
    ack_pulse();
    pwm(3, 5, 0);
    chk("stuck_rearm_no_capture", bus.meas_valid, 0);
    pwm(2, 6, 0);
    chk_res("after_stuck", 8, 3, 1);
    timeout = '0;
    pwm_in = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(3);
    pwm_in = 1'b0;
    tick(2);
    chk_res("disabled_hold", 8, 3, 1);
    chk("disabled_overrun", bus.overrun, 1);
    chk("disabled_stuck", bus.stuck, 1);
    enable = 1'b1;
    tick(1);
    chk("enable_rise_overrun", bus.overrun, 0);
    chk("enable_rise_stuck", bus.stuck, 0);
    ack_pulse();
    pwm(6, 2, 0);
    chk("reenable_no_capture", bus.meas_valid, 0);
    pwm(2, 2, 0);
    chk_res("reenable", 8, 6, 1);
    ack_pulse();
    pwm_in = 1'b1;
    tick(300);
    chk("sat_pcnt", dut.pcnt, 255);
    chk("sat_hcnt", dut.hcnt, 255);
    chk_res("pre_sat", 5, 2, 1);
    pwm_in = 1'b0;
    tick(2);
    pwm(1, 3, 0);
    chk_res("saturated", 255, 255, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_res("async_reset", 0, 0, 0);
    chk("async_reset_overrun", bus.overrun, 0);
    chk("async_reset_stuck", bus.stuck, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    pwm(3, 5, 0);
    chk("post_reset_no_capture", bus.meas_valid, 0);
    pwm(3, 5, 0);
    chk_res("post_reset", 8, 3, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
